// File: rtl/ysyx_23060240_csr_pkg.sv
// Shared definitions for the CSR execute unit: FSM encoding, funct3 codes,
// machine-mode CSR addresses and small decode helpers.
package ysyx_23060240_csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_TRAP  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Every funct3 with a non-zero low pair is a Zicsr op; 000 and 100 are not.
  function automatic logic is_csr_op(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

  // Set/clear with a zero source (x0 or zimm=0) must not write the CSR.
  function automatic logic skip_write(input logic [2:0] f3, input logic [4:0] rs1);
    return f3[1] && (rs1 == 5'd0);
  endfunction

  function automatic logic is_known_csr(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/ysyx_23060240_csr_alu.sv
// Combinational CSR new-value computation: write, set bits or clear bits.
module ysyx_23060240_csr_alu
  import ysyx_23060240_csr_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_src,
  input  logic [31:0] i_old,
  output logic [31:0] o_new
);

  always_comb begin
    o_new = i_old;
    case (i_funct3)
      F3_CSRRW, F3_CSRRWI: o_new = i_src;
      F3_CSRRS, F3_CSRRSI: o_new = i_old | i_src;
      F3_CSRRC, F3_CSRRCI: o_new = i_old & ~i_src;
      default:             o_new = i_old;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_csr_exu.sv
// CSR execute unit: sequences read/modify/write of one CSR per command and
// handles ecall/mret by fetching the redirect target from the CSR file.
module ysyx_23060240_csr_exu
  import ysyx_23060240_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload hold stable until that edge.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic        is_ecall,
  input  logic        is_mret,
  output logic [11:0] csr_addr_o,
  output logic [31:0] pc_o,
  output logic        r_csr_en,
  input  logic [31:0] r_csr_data,
  output logic        w_csr_en,
  output logic [31:0] w_csr_data,
  output logic        jump_ecall,
  output logic        jump_mret,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        rd_wen,
  output logic [31:0] rd_wdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [2:0]  o_dbg_state
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_pc;
  logic [2:0]  r_funct3;
  logic [11:0] r_csr_addr;
  logic [4:0]  r_rs1_idx;
  logic [31:0] r_rs1_data;
  logic        r_is_ecall;
  logic        r_is_mret;
  logic [31:0] r_old;
  logic [31:0] r_redirect_pc;
  logic        r_rd_wen;
  logic        r_redirect;
  logic        w_accept;
  logic        w_trap_cmd;
  logic [31:0] w_src;
  logic [31:0] w_new;

  assign w_accept   = in_valid && in_ready;
  assign w_trap_cmd = is_ecall || is_mret;
  assign w_src      = r_funct3[2] ? {27'b0, r_rs1_idx} : r_rs1_data;

  ysyx_23060240_csr_alu u_alu (
    .i_funct3 (r_funct3),
    .i_src    (w_src),
    .i_old    (r_old),
    .o_new    (w_new)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_trap_cmd)             w_next = ST_TRAP;
          else if (is_csr_op(funct3)) w_next = ST_READ;
          else                        w_next = ST_RESP;
        end
      end
      ST_READ:  w_next = skip_write(r_funct3, r_rs1_idx) ? ST_RESP : ST_WRITE;
      ST_WRITE: w_next = ST_RESP;
      ST_TRAP:  w_next = ST_RESP;
      ST_RESP:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_funct3      <= '0;
      r_csr_addr    <= '0;
      r_rs1_idx     <= '0;
      r_rs1_data    <= '0;
      r_is_ecall    <= 1'b0;
      r_is_mret     <= 1'b0;
      r_old         <= '0;
      r_redirect_pc <= '0;
      r_rd_wen      <= 1'b0;
      r_redirect    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pc          <= pc;
        r_funct3      <= funct3;
        r_csr_addr    <= csr_addr;
        r_rs1_idx     <= rs1_idx;
        r_rs1_data    <= rs1_data;
        r_is_ecall    <= is_ecall;
        r_is_mret     <= is_mret;
        r_old         <= '0;
        r_redirect_pc <= '0;
        r_rd_wen      <= !w_trap_cmd && is_csr_op(funct3);
        r_redirect    <= w_trap_cmd;
      end
      if (r_state == ST_READ) r_old <= r_csr_data;
      // The CSR file answers a jump strobe with mtvec (ecall) or mepc (mret).
      if (r_state == ST_TRAP) r_redirect_pc <= r_csr_data;
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign r_csr_en    = (r_state == ST_READ);
  assign w_csr_en    = (r_state == ST_WRITE);
  assign w_csr_data  = (r_state == ST_WRITE) ? w_new : 32'd0;
  assign jump_ecall  = (r_state == ST_TRAP) && r_is_ecall;
  assign jump_mret   = (r_state == ST_TRAP) && r_is_mret && !r_is_ecall;
  assign out_valid   = (r_state == ST_RESP);
  assign rd_wen      = (r_state == ST_RESP) && r_rd_wen;
  assign redirect    = (r_state == ST_RESP) && r_redirect;
  assign rd_wdata    = r_old;
  assign redirect_pc = r_redirect_pc;
  assign csr_addr_o  = r_csr_addr;
  assign pc_o        = r_pc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_23060240_csr_exu.sv
// Directed bench for the CSR execute unit: the driver pushes hand-computed
// responses into a queue, a negedge monitor pops and compares them.
module tb_ysyx_23060240_csr_exu;
  import ysyx_23060240_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] pc;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic        is_ecall, is_mret;
  logic [11:0] csr_addr_o;
  logic [31:0] pc_o;
  logic        r_csr_en;
  logic [31:0] r_csr_data;
  logic        w_csr_en;
  logic [31:0] w_csr_data;
  logic        jump_ecall, jump_mret;
  logic        out_valid, out_ready;
  logic        rd_wen;
  logic [31:0] rd_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  o_dbg_state;

  typedef struct packed {
    logic [2:0]  lat;
    logic        wr;
    logic [31:0] wdata;
    logic        ecall;
    logic        mret;
    logic        rd_wen;
    logic        redirect;
    logic [31:0] rdata;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [11:0] addr;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  int          r_cnt, w_cnt, e_cnt, m_cnt;
  logic [31:0] w_cap, pc_cap;
  logic        seen;

  ysyx_23060240_csr_exu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pc          (pc),
    .funct3      (funct3),
    .csr_addr    (csr_addr),
    .rs1_idx     (rs1_idx),
    .rs1_data    (rs1_data),
    .is_ecall    (is_ecall),
    .is_mret     (is_mret),
    .csr_addr_o  (csr_addr_o),
    .pc_o        (pc_o),
    .r_csr_en    (r_csr_en),
    .r_csr_data  (r_csr_data),
    .w_csr_en    (w_csr_en),
    .w_csr_data  (w_csr_data),
    .jump_ecall  (jump_ecall),
    .jump_mret   (jump_mret),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rd_wen      (rd_wen),
    .rd_wdata    (rd_wdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst_n) begin
      r_cnt = 0; w_cnt = 0; e_cnt = 0; m_cnt = 0;
      w_cap = '0; pc_cap = '0; seen = 1'b0;
    end else begin
      if (r_csr_en || w_csr_en || jump_ecall || jump_mret)
        chk("strobe_onehot", $countones({r_csr_en, w_csr_en, jump_ecall, jump_mret}), 1);
      if (r_csr_en) r_cnt++;
      if (w_csr_en) begin w_cnt++; w_cap = w_csr_data; end
      if (jump_ecall) begin e_cnt++; pc_cap = pc_o; end
      if (jump_mret) begin m_cnt++; pc_cap = pc_o; end
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("resp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("latency", cyc - a, {29'd0, e.lat});
          chk("rd_wen", rd_wen, e.rd_wen);
          chk("redirect", redirect, e.redirect);
          if (e.rd_wen) chk("rd_wdata", rd_wdata, e.rdata);
          if (e.redirect) chk("redirect_pc", redirect_pc, e.rpc);
          chk("read_pulses", r_cnt, {31'd0, e.rd_wen});
          chk("write_pulses", w_cnt, {31'd0, e.wr});
          if (e.wr) chk("w_csr_data", w_cap, e.wdata);
          chk("ecall_pulses", e_cnt, {31'd0, e.ecall});
          chk("mret_pulses", m_cnt, {31'd0, e.mret});
          if (e.ecall || e.mret) chk("trap_pc_o", pc_cap, e.pc);
          chk("pc_o_latched", pc_o, e.pc);
          chk("csr_addr_o", {20'd0, csr_addr_o}, {20'd0, e.addr});
        end
        r_cnt = 0; w_cnt = 0; e_cnt = 0; m_cnt = 0;
      end else if (!out_valid) begin
        seen = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                       input logic [31:0] data, input logic [31:0] p, input logic ec,
                       input logic mr, input logic [31:0] csr_val, input logic [2:0] lat,
                       input logic wr, input logic [31:0] wdata, input logic wen,
                       input logic rdir, input logic [31:0] rdata, input logic [31:0] rpc,
                       input logic e_ec, input logic e_mr, input int stall);
    exp_t        e;
    logic        got;
    logic [31:0] snap_data, snap_rpc;
    logic [3:0]  snap_flags;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    funct3 = f3; csr_addr = addr; rs1_idx = idx; rs1_data = data; pc = p;
    is_ecall = ec; is_mret = mr; r_csr_data = csr_val; in_valid = 1'b1;
    e = '{lat: lat, wr: wr, wdata: wdata, ecall: e_ec, mret: e_mr, rd_wen: wen,
          redirect: rdir, rdata: rdata, rpc: rpc, pc: p, addr: addr};
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc = $urandom; rs1_data = $urandom; csr_addr = 12'($urandom_range(0, 4095));
    is_ecall = 1'b0; is_mret = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    chk("resp_within_budget", got, 1);
    snap_data = rd_wdata; snap_rpc = redirect_pc;
    snap_flags = {out_valid, rd_wen, redirect, in_ready};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_flags", {out_valid, rd_wen, redirect, in_ready}, {snap_flags[3:1], 1'b0});
      chk("stall_rd_wdata", rd_wdata, snap_data);
      chk("stall_redirect_pc", redirect_pc, snap_rpc);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic got;
    logic quiet;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pc = '0; funct3 = '0;
    csr_addr = '0; rs1_idx = '0; rs1_data = '0; is_ecall = 1'b0; is_mret = 1'b0;
    r_csr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_strobes", {r_csr_en, w_csr_en, jump_ecall, jump_mret}, 0);
    chk("rst_rd_wdata", rd_wdata, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_csr_addr_o", {20'd0, csr_addr_o}, 0);
    chk("rst_state", o_dbg_state, ST_IDLE);
    rst_n = 1'b1;

    //     f3      addr         idx   rs1_data      pc            ec mr csr_val      lat wr wdata         wen rd rdata        rpc           eE eM stall
    issue(3'b001, CSR_MTVEC,   5'd5, 32'h80000100, 32'h80000000, 0, 0, 32'h0,        3, 1, 32'h80000100, 1, 0, 32'h0,        32'h0,        0, 0, 0);
    issue(3'b010, CSR_MSTATUS, 5'd0, 32'hDEADBEEF, 32'h80000004, 0, 0, 32'h00001800, 2, 0, 32'h0,        1, 0, 32'h00001800, 32'h0,        0, 0, 0);
    issue(3'b111, CSR_MEPC,    5'd3, 32'hFFFFFFFF, 32'h80000008, 0, 0, 32'h8000000F, 3, 1, 32'h8000000C, 1, 0, 32'h8000000F, 32'h0,        0, 0, 0);
    issue(3'b000, 12'h000,     5'd0, 32'h0,        32'h80000040, 1, 0, 32'h80000100, 2, 0, 32'h0,        0, 1, 32'h0,        32'h80000100, 1, 0, 0);
    issue(3'b000, 12'h000,     5'd0, 32'h0,        32'h80000080, 1, 1, 32'h80000200, 2, 0, 32'h0,        0, 1, 32'h0,        32'h80000200, 1, 0, 0);
    issue(3'b000, 12'h000,     5'd0, 32'h0,        32'h80000100, 0, 1, 32'h80000044, 2, 0, 32'h0,        0, 1, 32'h0,        32'h80000044, 0, 1, 0);
    issue(3'b000, CSR_MCAUSE,  5'd9, 32'h11111111, 32'h8000000C, 0, 0, 32'h22222222, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0);
    issue(3'b010, CSR_MCAUSE,  5'd2, 32'h0000F000, 32'h80000010, 0, 0, 32'h00000A0B, 3, 1, 32'h0000FA0B, 1, 0, 32'h00000A0B, 32'h0,        0, 0, 5);
    issue(3'b110, CSR_MSTATUS, 5'd0, 32'hFFFFFFFF, 32'h80000014, 0, 0, 32'h00000055, 2, 0, 32'h0,        1, 0, 32'h00000055, 32'h0,        0, 0, 0);
    issue(3'b011, CSR_MEPC,    5'd7, 32'h000000FF, 32'h80000018, 0, 0, 32'h00001234, 3, 1, 32'h00001200, 1, 0, 32'h00001234, 32'h0,        0, 0, 0);
    issue(3'b101, CSR_MTVEC,   5'd0, 32'h12345678, 32'h8000001C, 0, 0, 32'h00000077, 3, 1, 32'h0,        1, 0, 32'h00000077, 32'h0,        0, 0, 0);
    issue(3'b100, CSR_MTVEC,   5'd4, 32'h0,        32'h80000020, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 2);

    // Abort a csrrw in its WRITE cycle; nothing may follow the reset.
    @(negedge clk);
    funct3 = 3'b001; csr_addr = CSR_MTVEC; rs1_idx = 5'd1; rs1_data = 32'hCAFE0000;
    pc = 32'h80000024; r_csr_data = 32'h0000BEEF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (w_csr_en) begin got = 1'b1; break; end
    end
    chk("abort_reached_write", got, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_w_csr_en", w_csr_en, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_state", o_dbg_state, ST_IDLE);
    chk("abort_rd_wdata", rd_wdata, 0);
    chk("abort_pc_o", pc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (r_csr_en || w_csr_en || jump_ecall || jump_mret || out_valid) quiet = 1'b0;
    end
    chk("abort_quiet", quiet, 1);

    issue(3'b001, CSR_MTVEC,   5'd5, 32'h80000100, 32'h80000028, 0, 0, 32'h0000BEEF, 3, 1, 32'h80000100, 1, 0, 32'h0000BEEF, 32'h0,        0, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_csr_exu.md
YSYX_23060240_CSR_EXU -- requirements
Module: ysyx_23060240_csr_exu

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (rising edge).
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  in  1 / in_ready  out  1  command handshake from decode.
REQ-004 SHALL have ports: pc  in  32, funct3  in  3, csr_addr  in  12, rs1_idx  in  5 (also zimm), rs1_data  in  32, is_ecall  in  1, is_mret  in  1.
REQ-005 SHALL have ports toward the CSR file: csr_addr_o  out  12, pc_o  out  32, r_csr_en  out  1, r_csr_data  in  32, w_csr_en  out  1, w_csr_data  out  32, jump_ecall  out  1, jump_mret  out  1.
REQ-006 SHALL have ports toward writeback/fetch: out_valid  out  1, out_ready  in  1, rd_wen  out  1, rd_wdata  out  32, redirect  out  1, redirect_pc  out  32.

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, TRAP, RESP; in_ready=1 only in IDLE.
REQ-008 SHALL latch pc, funct3, csr_addr, rs1_idx, rs1_data, is_ecall, is_mret on the cycle in which in_valid&in_ready is high; csr_addr_o and pc_o SHALL drive the latched values.
REQ-009 IDLE transitions on accept: is_ecall -> TRAP (ecall); else is_mret -> TRAP (mret); else funct3 in {001,010,011,101,110,111} -> READ; else -> RESP with rd_wen=0, redirect=0, no CSR strobes.
REQ-010 SHALL give is_ecall priority over is_mret when both are high.
REQ-011 READ: r_csr_en=1 for exactly one cycle; old value captured from r_csr_data into rd_wdata register.
REQ-012 Source operand SHALL be rs1_data for funct3[2]=0 and {27'b0, rs1_idx} for funct3[2]=1.
REQ-013 New value SHALL be: funct3[1:0]=01 -> src; 10 -> old|src; 11 -> old&~src.
REQ-014 READ -> WRITE unless funct3[1:0] in {10,11} and rs1_idx==0, in which case READ -> RESP (no write).
REQ-015 WRITE: w_csr_en=1 and w_csr_data=new value for exactly one cycle, r_csr_en=0; WRITE -> RESP.
REQ-016 TRAP: exactly one of jump_ecall/jump_mret high for one cycle, r_csr_en=0, w_csr_en=0; r_csr_data captured into redirect_pc (mtvec for ecall, mepc for mret); TRAP -> RESP.
REQ-017 RESP: out_valid=1; rd_wen=1 for CSR ops, 0 for traps/illegal; redirect=1 for traps only; outputs SHALL hold stable until out_valid&out_ready, then -> IDLE.
REQ-018 Latency from accept edge to out_valid: write ops 3 cycles, no-write ops 2, traps 2, illegal 1.
REQ-019 All CSR strobes (r_csr_en, w_csr_en, jump_ecall, jump_mret) SHALL be 0 outside their named state and never two high at once.

Reset
REQ-020 rst_n low SHALL asynchronously force state IDLE and clear all latched registers and outputs to 0, except in_ready which reads 1 after reset.
REQ-021 Reset asserted mid-operation SHALL abort it with no further CSR strobes; a pending RESP is discarded.

Structure
REQ-022 State encoding, funct3 constants and CSR addresses (300, 305, 341, 342) SHALL live in the shared package.
REQ-023 New-value computation SHALL be a combinational sub-module ysyx_23060240_csr_alu (funct3, src, old -> new).

Verification
REQ-024 csrrw 0x305, rs1_data=0x80000100, old=0 -> READ, WRITE with w_csr_data=0x80000100, out_valid 3 cycles after accept, rd_wdata=0.
REQ-025 csrrs 0x300, rs1_idx=0, old=0x1800 -> no w_csr_en pulse, out_valid at 2 cycles, rd_wdata=0x1800.
REQ-026 csrrci 0x341, zimm=0x3, old=0x8000000F -> w_csr_data=0x8000000C, rd_wdata=0x8000000F.
REQ-027 ecall pc=0x80000040, mtvec=0x80000100 -> single jump_ecall pulse with pc_o=0x80000040, redirect=1, redirect_pc=0x80000100, rd_wen=0; is_ecall&is_mret together -> ecall only.
REQ-028 out_ready held low 5 cycles in RESP -> outputs stable, in_ready=0; rst_n low during WRITE -> w_csr_en drops immediately, IDLE, in_ready=1.
